tl_ped_request: RTL
===================

Name: tl_ped_request

Overview:
- Upstream front-end for the intersection traffic-light controller.
- Conditions two raw pedestrian push-buttons (north/south and east/west crossings): synchronise, debounce, detect press edges.
- Holds each press as a sticky request until the light controller acknowledges it with a req/ack handshake.
- Also produces the 1-second phase tick that the controller's phase timer counts.

Parameters:
- DEBOUNCE_CYCLES, 1000, consecutive cycles a synchronised sample must differ from the accepted level before it is accepted; legal range >= 2.
- TICK_DIV, 100, clock cycles per tick_1s pulse; legal range >= 2.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- btn_ns_raw  input  1  raw N/S crossing button, asynchronous, active-high
- btn_ew_raw  input  1  raw E/W crossing button, asynchronous, active-high
- ack_ns  input  1  one-cycle pulse from light controller: N/S request served
- ack_ew  input  1  one-cycle pulse from light controller: E/W request served
- req_ns  output  1  N/S pedestrian request pending
- req_ew  output  1  E/W pedestrian request pending
- btn_ns_db  output  1  debounced N/S button level
- btn_ew_db  output  1  debounced E/W button level
- tick_1s  output  1  one-cycle pulse every TICK_DIV cycles

Interface rule: one clock (clk); reset is asynchronous and active-low (rst_n).

Behaviour:
- Reset: all flops clear asynchronously on rst_n low, including sync stages, debounce counters, accepted levels, request FSMs and tick counter. All outputs are 0 during reset and in the first cycle after release.
- Synchroniser: per channel, a 2-flop chain. sync output = raw value sampled 2 edges earlier.
- Debounce, per channel:
  - Counter width is $clog2(DEBOUNCE_CYCLES).
  - If sync output equals btn_*_db, counter is 0.
  - Otherwise counter increments. When counter == DEBOUNCE_CYCLES-1 and the sample still differs, btn_*_db toggles at the next edge and counter returns to 0.
  - Any agreeing sample mid-count resets counter to 0; glitches shorter than DEBOUNCE_CYCLES are rejected.
- Edge detect: press = btn_*_db rising (registered previous level).
- Request FSM per channel, states IDLE and PEND:
  - IDLE: req=0; press -> PEND.
  - PEND: req=1; ack -> IDLE; further presses ignored.
  - ack and press in the same cycle while PEND -> stays PEND; the new press is not lost.
  - ack while IDLE: ignored, no state change.
- Latency: steady raw high first sampled at edge 0 -> req high after edge DEBOUNCE_CYCLES+3. req drops on the edge that samples ack.
- Holding the button does not re-request; a new request needs release, debounce low, then press again.
- Channels are fully independent; simultaneous presses yield simultaneous reqs.
- Tick:
  - Counter 0..TICK_DIV-1, wraps to 0.
  - tick_1s=1 in the cycle the counter equals TICK_DIV-1; exactly one cycle per period.
  - First pulse TICK_DIV cycles after reset release.
  - Free-running; unaffected by buttons.
- Reset mid-operation: pending requests are discarded; the tick phase restarts at 0.

Optional Feature:
- Macro: TL_REQ_STATS_EN.
- Defined: adds outputs req_cnt_ns and req_cnt_ew, 8 bits each. Each counts accepted IDLE->PEND transitions, saturates at 255, and clears only on reset.
- Undefined: those ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package tl_pkg holds:
  - req_state_t enum {REQ_IDLE, REQ_PEND}
  - default constants TL_DEBOUNCE_CYCLES_DEF=1000 and TL_TICK_DIV_DEF=100
  - TL_REQ_CNT_W=8
- Sub-module tl_debounce (2-flop sync + debounce counter + accepted level, param DEBOUNCE_CYCLES), instantiated once per channel.
- Edge detect, request FSMs, tick counter and optional stats stay in tl_ped_request.

Test Plan (DEBOUNCE_CYCLES=4, TICK_DIV=10):
- Clean press: btn_ns_raw held high from edge 0 -> btn_ns_db=1 after edge 6, req_ns=1 after edge 7. ack_ns pulse at edge 20 -> req_ns=0 after edge 20. req_ew stays 0 throughout.
- Glitch reject: btn_ew_raw high for 3 cycles, then low -> btn_ew_db and req_ew never assert. Repeat with 4 cycles high -> accepted.
- Hold/no-retrigger: hold btn_ns_raw high 100 cycles, ack at cycle 30 -> exactly one request. After release, debounce, and re-press -> second request.
- Simultaneous ack+press: req_ns pending; release and re-press timed so the debounced rising edge coincides with ack_ns -> req_ns stays 1.
- Tick and reset: tick_1s pulses at cycles 10, 20, 30 after reset release. Assert rst_n low at cycle 25 with req_ew pending -> all outputs 0 immediately. After release, next tick 10 cycles later and req_ew stays 0.
- With TL_REQ_STATS_EN: 300 separate N/S presses each acked -> req_cnt_ns=255 saturated, req_cnt_ew=0.

Source files
------------

// File: rtl/tl_pkg.sv
// Shared types and defaults for the pedestrian request front-end.
package tl_pkg;

    typedef enum logic {
        REQ_IDLE = 1'b0,
        REQ_PEND = 1'b1
    } req_state_t;

    localparam int TL_DEBOUNCE_CYCLES_DEF = 1000;
    localparam int TL_TICK_DIV_DEF        = 100;
    localparam int TL_REQ_CNT_W           = 8;

    function automatic logic [TL_REQ_CNT_W-1:0] sat_inc(input logic [TL_REQ_CNT_W-1:0] v);
        return (v == {TL_REQ_CNT_W{1'b1}}) ? v : v + TL_REQ_CNT_W'(1);
    endfunction

endpackage

// File: rtl/tl_debounce.sv
// One button channel: synchroniser, retiming flop and debounce counter
// producing the accepted (debounced) level.
module tl_debounce
    import tl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = TL_DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic db
);

    localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             meta;
    logic             sync;
    logic             sample;
    logic [CNT_W-1:0] cnt;

    // meta/sync form the metastability chain; sample retimes the synchronised
    // level so a press first sampled at edge 0 is accepted after edge D+2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta   <= 1'b0;
            sync   <= 1'b0;
            sample <= 1'b0;
            cnt    <= '0;
            db     <= 1'b0;
        end else begin
            meta   <= raw;
            sync   <= meta;
            sample <= sync;
            if (sample == db) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                db  <= ~db;
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/tl_ped_request.sv
// Pedestrian request front-end: debounced buttons, sticky req/ack requests
// and the phase tick. Optional request counters under TL_REQ_STATS_EN.
module tl_ped_request
    import tl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = TL_DEBOUNCE_CYCLES_DEF,
    parameter int TICK_DIV        = TL_TICK_DIV_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_ns_raw,
    input  logic btn_ew_raw,
    input  logic ack_ns,
    input  logic ack_ew,
    output logic req_ns,
    output logic req_ew,
    output logic btn_ns_db,
    output logic btn_ew_db,
    output logic tick_1s
`ifdef TL_REQ_STATS_EN
    ,
    output logic [TL_REQ_CNT_W-1:0] req_cnt_ns,
    output logic [TL_REQ_CNT_W-1:0] req_cnt_ew
`endif
);

    localparam int                TICK_W    = $clog2(TICK_DIV);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

    logic       db_ns;
    logic       db_ew;
    logic [1:0] db;
    logic [1:0] db_prev;
    logic [1:0] press;
    logic [1:0] ack;
    logic [1:0] req_q;
    req_state_t state [2];
    logic [TICK_W-1:0] tick_cnt;

    tl_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_ns (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (btn_ns_raw),
        .db    (db_ns)
    );

    tl_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_ew (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (btn_ew_raw),
        .db    (db_ew)
    );

    assign db    = {db_ew, db_ns};
    assign ack   = {ack_ew, ack_ns};
    assign press = db & ~db_prev;

    // Index 0 is N/S, index 1 is E/W. A press arriving with the ack keeps
    // the request pending so that press is not lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_prev  <= '0;
            req_q    <= '0;
            state[0] <= REQ_IDLE;
            state[1] <= REQ_IDLE;
        end else begin
            db_prev <= db;
            for (int c = 0; c < 2; c++) begin
                case (state[c])
                    REQ_IDLE: begin
                        if (press[c]) begin
                            state[c] <= REQ_PEND;
                            req_q[c] <= 1'b1;
                        end
                    end
                    REQ_PEND: begin
                        if (ack[c] && !press[c]) begin
                            state[c] <= REQ_IDLE;
                            req_q[c] <= 1'b0;
                        end
                    end
                    default: begin
                        state[c] <= REQ_IDLE;
                        req_q[c] <= 1'b0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt <= '0;
        end else if (tick_cnt == TICK_LAST) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TICK_W'(1);
        end
    end

    assign tick_1s   = (tick_cnt == TICK_LAST);
    assign req_ns    = req_q[0];
    assign req_ew    = req_q[1];
    assign btn_ns_db = db_ns;
    assign btn_ew_db = db_ew;

`ifdef TL_REQ_STATS_EN
    logic [TL_REQ_CNT_W-1:0] cnt_q [2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q[0] <= '0;
            cnt_q[1] <= '0;
        end else begin
            for (int c = 0; c < 2; c++) begin
                if (state[c] == REQ_IDLE && press[c]) begin
                    cnt_q[c] <= sat_inc(cnt_q[c]);
                end
            end
        end
    end

    assign req_cnt_ns = cnt_q[0];
    assign req_cnt_ew = cnt_q[1];
`endif

endmodule
